mul_seq_nbit: RTL and testbench

//  Sequential radix-2 shift-add multiplier with start/done handshake, a fixed

---
 rtl/mul_seq_nbit.sv | 159 +++++++++++++++
 tb/tb_mul_seq_nbit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: sequential radix-2 shift-add multiplier with per-operand signed/unsigned select.
// Latency: start sampled at edge k, done pulses for one cycle after edge k+N+1 (N+1 cycles).
// Backpressure: none; start is only honoured in IDLE, and starts while busy are dropped.
//
// Ports:
//   clk_i               rising-edge clock
//   rst_i               asynchronous active-high reset
//   start_i             request, sampled only in IDLE together with the operands
//   sgn0_i / sgn1_i     1 = corresponding operand is two's complement, 0 = unsigned
//   src0_i / src1_i     multiplicand / multiplier (N bits)
//   busy_o              high while an operation is in RUN or FIX
//   done_o              one-cycle pulse, product valid on dst_*
//   dst_hi_o / dst_lo_o product bits [2N-1:N] / [N-1:0], held until the next result
module mul_seq_nbit #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         sgn0_i,
    input  logic         sgn1_i,
    input  logic [N-1:0] src0_i,
    input  logic [N-1:0] src1_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] dst_hi_o,
    output logic [N-1:0] dst_lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [N:0]     acc_q, acc_d;      // upper N+1 bits of the 2N+1-bit accumulator
    logic           neg_q, neg_d;
    logic           done_q, done_d;
    logic [N-1:0]   dst_hi_q, dst_hi_d;
    logic [N-1:0]   dst_lo_q, dst_lo_d;

    logic [N-1:0]   mag0, mag1;
    logic           neg0, neg1;
    logic [N:0]     sum;
    logic [2*N-1:0] prod, res;
    logic           last_iter;

    // Operand magnitudes. -2^(N-1) negates to 2^(N-1), which still fits in
    // N unsigned bits, so no extra width is needed here.
    assign neg0 = sgn0_i & src0_i[N-1];
    assign neg1 = sgn1_i & src1_i[N-1];
    assign mag0 = neg0 ? -src0_i : src0_i;
    assign mag1 = neg1 ? -src1_i : src1_i;

    // acc_q[N] is always zero after a shift, so this addition cannot overflow
    // N+1 bits; the carry lands in sum[N] and is shifted back down.
    assign sum  = acc_q + {1'b0, (mplier_q[0] ? mcand_q : '0)};

    // After N iterations the unsigned product sits in {acc[N-1:0], mplier}.
    assign prod = {acc_q[N-1:0], mplier_q};
    assign res  = neg_q ? -prod : prod;

    assign last_iter = (cnt_q == M'(N - 1));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)   state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_FIX;
            S_FIX:                  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = done_q;
        dst_hi_o = dst_hi_q;
        dst_lo_o = dst_lo_q;
    end

    // ---------------------------------------------------------------- datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        dst_hi_d = dst_hi_q;
        dst_lo_d = dst_lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d  = mag0;
                    mplier_d = mag1;
                    neg_d    = neg0 ^ neg1;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                // Conditional add then shift {acc, mplier} right by one; the
                // bit leaving acc enters the top of the multiplier register.
                acc_d    = {1'b0, sum[N:1]};
                mplier_d = {sum[0], mplier_q[N-1:1]};
                cnt_d    = cnt_q + M'(1);
            end
            S_FIX: begin
                dst_hi_d = res[2*N-1:N];
                dst_lo_d = res[N-1:0];
                done_d   = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            dst_hi_q <= '0;
            dst_lo_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            dst_hi_q <= dst_hi_d;
            dst_lo_q <= dst_lo_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_nbit.sv
// tb_mul_seq_nbit: scoreboard bench for mul_seq_nbit at N=32 and N=8.
// Expected products and done cycles are queued at each accepted start and popped on done.
// A done with an empty queue, a wrong product or a wrong done cycle is reported.
module tb_mul_seq_nbit;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    logic [63:0] last32 = '0;

    // N=32 instance
    logic        start32 = 1'b0, s0_32 = 1'b0, s1_32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] hi32, lo32;

    // N=8 instance
    logic        start8 = 1'b0, s0_8 = 1'b0, s1_8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    mul_seq_nbit #(.N(32), .M(5)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .sgn0_i(s0_32), .sgn1_i(s1_32),
        .src0_i(a32), .src1_i(b32), .busy_o(busy32), .done_o(done32),
        .dst_hi_o(hi32), .dst_lo_o(lo32)
    );

    mul_seq_nbit #(.N(8), .M(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .sgn0_i(s0_8), .sgn1_i(s1_8),
        .src0_i(a8), .src1_i(b8), .busy_o(busy8), .done_o(done8),
        .dst_hi_o(hi8), .dst_lo_o(lo8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: sign/zero-extend to a wide signed type and multiply.
    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic s0, input logic s1);
        logic signed [65:0] ea, eb, p;
        ea = s0 ? {{34{a[31]}}, a} : {34'b0, a};
        eb = s1 ? {{34{b[31]}}, b} : {34'b0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s0, input logic s1);
        logic signed [17:0] ea, eb, p;
        ea = s0 ? {{10{a[7]}}, a} : {10'b0, a};
        eb = s1 ? {{10{b[7]}}, b} : {10'b0, b};
        p  = ea * eb;
        return p[15:0];
    endfunction

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                check("spurious_done32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check("prod32", {hi32, lo32}, e.prod);
                check("latency32", 64'(cyc), 64'(e.cyc));
                last32 = e.prod;
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("spurious_done8", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check("prod8", {48'b0, hi8, lo8}, e.prod);
                check("latency8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one start edge; push an expectation only if the DUT should accept it.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic s0, input logic s1, input bit accept);
        exp_t e;
        @(negedge clk);
        a32 = a; b32 = b; s0_32 = s0; s1_32 = s1; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; s0_32 = 1'($urandom); s1_32 = 1'($urandom);
        if (accept) begin
            e.prod = ref32(a, b, s0, s1);
            e.cyc  = cyc + 33;
            q32.push_back(e);
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic s0, input logic s1);
        exp_t e;
        @(negedge clk);
        a8 = a; b8 = b; s0_8 = s0; s1_8 = s1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        e.prod = {48'b0, ref8(a, b, s0, s1)};
        e.cyc  = cyc + 9;
        q8.push_back(e);
    endtask

    task automatic wait_idle32();
        for (int i = 0; i < 120 && q32.size() != 0; i++) @(negedge clk);
        if (q32.size() != 0) begin
            check("timeout32", 64'(q32.size()), 64'd0);
            q32.delete();
        end
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            check("timeout8", 64'(q8.size()), 64'd0);
            q8.delete();
        end
    endtask

    // Full op with mid-run checks: busy high and dst still holding the previous result.
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic s0, input logic s1);
        issue32(a, b, s0, s1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_run", 64'(busy32), 64'd1);
        check("dst_hold", {hi32, lo32}, last32);
        wait_idle32();
    endtask

    logic [7:0] corner [6];

    initial begin
        corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
        corner[3] = 8'h80; corner[4] = 8'h81; corner[5] = 8'hFF;

        // Reset state
        #3;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_dst", {hi32, lo32}, 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1 unsigned
        run32(32'd5, 32'd2, 1'b0, 1'b0);
        check("t1_value", {hi32, lo32}, 64'd10);
        // T2 mixed signs
        run32(32'hFFFFFFFD, 32'd7, 1'b1, 1'b1);
        check("t2_signed", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);
        run32(32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        check("t2_unsigned", {hi32, lo32}, 64'h00000006_FFFFFFEB);
        // T3 extremes
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("t3_max_u", {hi32, lo32}, 64'hFFFFFFFE_00000001);
        run32(32'h80000000, 32'h80000000, 1'b1, 1'b1);
        check("t3_min_s", {hi32, lo32}, 64'h40000000_00000000);
        run32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("t3_mixed", {hi32, lo32}, 64'h80000000_80000000);
        for (int i = 0; i < 12; i++)
            run32($urandom, $urandom, 1'($urandom), 1'($urandom));

        // T4 start while busy is ignored
        issue32(32'd5, 32'd2, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        issue32(32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
        check("t4_busy", 64'(busy32), 64'd1);
        wait_idle32();
        check("t4_value", {hi32, lo32}, 64'd10);

        // T4 back-to-back: new start in the done cycle
        issue32(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done32) break;
        end
        check("b2b_done_seen", 64'(done32), 64'd1);
        check("b2b_busy_in_done", 64'(busy32), 64'd0);
        issue32(32'hFFFFFFF0, 32'd3, 1'b1, 1'b0, 1'b1);
        wait_idle32();

        // T5 reset mid-operation
        issue32(32'd5, 32'd2, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        q32.delete();
        last32 = '0;
        #1;
        check("t5_busy", 64'(busy32), 64'd0);
        check("t5_done", 64'(done32), 64'd0);
        check("t5_dst", {hi32, lo32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run32(32'd5, 32'd2, 1'b0, 1'b0);
        check("t5_restart", {hi32, lo32}, 64'd10);

        // T6 N=8: corners in every sign mode plus random pairs
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    issue8(corner[i], corner[j], m[1], m[0]);
                    wait_idle8();
                end
            end
            for (int r = 0; r < 400; r++) begin
                issue8(8'($urandom), 8'($urandom), m[1], m[0]);
                wait_idle8();
            end
        end

        repeat (3) @(negedge clk);
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
